// File: rtl/dev_job_ctrl.sv
// Job dispatcher for the dev iterative engine: operand FIFO, one-job-at-a-time issue,
// and an in-order result holding register toward a valid/ready consumer.
module dev_job_ctrl #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [W-1:0]             in_x_bi,
  input  logic [W-1:0]             in_y_bi,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [W-1:0]             dev_x_bo,
  output logic [W-1:0]             dev_y_bo,
  output logic                     dev_start_o,
  input  logic [W-1:0]             dev_y_bi,
  input  logic                     dev_rdy_i,
  output logic [W-1:0]             out_y_bo,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } job_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;

  job_t           mem [DEPTH];
  job_t           head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic           push;
  logic           pop;
  logic           capture;
  logic           accept;
  logic           start_nxt;
  logic           busy_nxt;

  // Ready depends on occupancy only, so a full FIFO refuses even while popping.
  assign in_ready_o = (count_o != CW'(DEPTH));
  assign head       = mem[rd_ptr];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop)        state_nxt = ISSUE;
      ISSUE:                     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!dev_rdy_i) state_nxt = WAIT_DONE;
      WAIT_DONE: if (dev_rdy_i)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output/control decode; a held result blocks the next pop so nothing is overwritten.
  always_comb begin
    push      = in_valid_i && in_ready_o;
    pop       = (state == IDLE) && (count_o != CW'(0)) && !out_valid_o;
    capture   = (state == WAIT_DONE) && dev_rdy_i;
    accept    = out_valid_o && out_ready_i;
    start_nxt = (state_nxt == ISSUE);
    busy_nxt  = (state_nxt != IDLE);
  end

  // Operand storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{x: in_x_bi, y: in_y_bi};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_o <= count_o + CW'(1);
      end else if (!push && pop) begin
        count_o <= count_o - CW'(1);
      end
    end
  end

  // Registered engine interface and status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dev_x_bo    <= '0;
      dev_y_bo    <= '0;
      dev_start_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (pop) begin
        dev_x_bo <= head.x;
        dev_y_bo <= head.y;
      end
      dev_start_o <= start_nxt;
      busy_o      <= busy_nxt;
    end
  end

  // Result holding register toward the consumer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_y_bo    <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (capture) begin
        out_y_bo    <= dev_y_bi;
        out_valid_o <= 1'b1;
      end else if (accept) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dev_job_ctrl.sv
// Scoreboard bench for dev_job_ctrl driving a stub engine (rdy low after start, y=x+y).
module tb_dev_job_ctrl;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_x, in_y;
  logic          in_valid, in_ready;
  logic [W-1:0]  dev_x, dev_y_op;
  logic          dev_start;
  logic [W-1:0]  dev_y_res;
  logic          dev_rdy;
  logic [W-1:0]  out_y;
  logic          out_valid, out_ready;
  logic          busy;
  logic [2:0]    count;

  always #5 clk = ~clk;

  dev_job_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_x_bi(in_x), .in_y_bi(in_y), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .dev_x_bo(dev_x), .dev_y_bo(dev_y_op), .dev_start_o(dev_start),
    .dev_y_bi(dev_y_res), .dev_rdy_i(dev_rdy),
    .out_y_bo(out_y), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .count_o(count)
  );

  // Stub engine: optional 3-cycle rdy hold after start, then 5 busy cycles; garbage y while busy
  logic          stub_hold;
  logic [W-1:0]  stub_sum;
  int            stub_cnt;
  int            stub_hcnt;

  always @(posedge clk) begin
    if (rst) begin
      dev_rdy   <= 1'b1;
      dev_y_res <= '0;
      stub_sum  <= '0;
      stub_cnt  <= 0;
      stub_hcnt <= 0;
    end else if (dev_start) begin
      stub_sum  <= dev_x + dev_y_op;
      dev_y_res <= 32'hDEADBEEF;
      stub_cnt  <= 5;
      if (stub_hold) stub_hcnt <= 3;
      else           dev_rdy   <= 1'b0;
    end else if (stub_hcnt != 0) begin
      stub_hcnt <= stub_hcnt - 1;
      if (stub_hcnt == 1) dev_rdy <= 1'b0;
    end else if (!dev_rdy) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        dev_rdy   <= 1'b1;
        dev_y_res <= stub_sum;
      end
    end
  end

  int passed = 0;
  int total  = 0;
  int acc_cnt = 0;
  int start_cnt = 0;
  logic prev_acc = 1'b0;
  logic prev_start = 1'b0;
  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] op_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    total++;
    $display("FAIL %s: timeout, got no handshake, required one within budget", name);
  endtask

  // Monitor: pops the scoreboard on every accepted result and every start pulse
  always @(negedge clk) begin
    if (rst) begin
      prev_acc   = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (prev_acc) check("out_valid_clear", 32'(out_valid), 32'd0);
      prev_acc = out_valid && out_ready;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check("unexpected_result", out_y, 32'hFFFF_FFFF);
        else check("result", out_y, exp_q.pop_front());
      end
      if (dev_start) begin
        logic [2*W-1:0] op;
        start_cnt++;
        check("start_one_cycle", 32'(prev_start), 32'd0);
        if (op_q.size() == 0) check("unexpected_start", dev_x, 32'hFFFF_FFFF);
        else begin
          op = op_q.pop_front();
          check("dev_x", dev_x, op[2*W-1:W]);
          check("dev_y", dev_y_op, op[W-1:0]);
        end
      end
      prev_start = dev_start;
    end
  end

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    in_x = x; in_y = y; in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_timeout("push");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(x + y);
      op_q.push_back({x, y});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_timeout("wait_valid");
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || count != 0 || busy || out_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) fail_timeout("drain");
  endtask

  logic pushes_done;
  int   s_acc, s_start;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    out_ready = 1'b1; stub_hold = 1'b0; pushes_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(dev_start), 32'd0);
    check("rst_out_y", out_y, 32'd0);

    // Single job (8,2) -> 10
    push(32'd8, 32'd2);
    drain();
    check("single_starts", 32'(start_cnt), 32'd1);
    check("single_results", 32'(acc_cnt), 32'd1);

    // Held result blocks pops; fill FIFO, 5th push waits for space
    s_acc = acc_cnt;
    set_ready(1'b0);
    push(32'd1, 32'd1);
    wait_valid();
    s_start = start_cnt;
    fork
      begin
        push(32'd10, 32'd1); push(32'd20, 32'd2); push(32'd30, 32'd3);
        push(32'd40, 32'd4); push(32'd50, 32'd5);
        pushes_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_no_start", 32'(start_cnt - s_start), 32'd0);
    check("full_held_valid", 32'(out_valid), 32'd1);
    check("full_idle", 32'(busy), 32'd0);
    set_ready(1'b1);
    begin
      int n = 0;
      while (!pushes_done && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!pushes_done) fail_timeout("fifth_push");
    end
    drain();
    check("full_results", 32'(acc_cnt - s_acc), 32'd6);

    // Consumer stall with 3 queued
    s_start = start_cnt;
    s_acc = acc_cnt;
    set_ready(1'b0);
    push(32'd7, 32'd1); push(32'd9, 32'd9); push(32'd100, 32'd200);
    wait_valid();
    repeat (20) @(negedge clk);
    check("stall_one_start", 32'(start_cnt - s_start), 32'd1);
    check("stall_count", 32'(count), 32'd2);
    check("stall_valid", 32'(out_valid), 32'd1);
    set_ready(1'b1);
    drain();
    check("stall_starts", 32'(start_cnt - s_start), 32'd3);
    check("stall_results", 32'(acc_cnt - s_acc), 32'd3);

    // Ten jobs pushed every cycle: pointers wrap
    s_acc = acc_cnt;
    for (int i = 0; i < 10; i++) push(32'(i * 3 + 1), 32'(i * i));
    drain();
    check("wrap_results", 32'(acc_cnt - s_acc), 32'd10);

    // Reset while the engine is computing with 2 queued
    push(32'd11, 32'd1); push(32'd12, 32'd2); push(32'd13, 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_count", 32'(count), 32'd2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    op_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    s_acc = acc_cnt;
    push(32'd3, 32'd4);
    drain();
    check("post_rst_results", 32'(acc_cnt - s_acc), 32'd1);

    // Engine keeps rdy high 3 cycles after start: no early capture of garbage y
    stub_hold = 1'b1;
    s_acc = acc_cnt;
    push(32'd100, 32'd23);
    drain();
    check("hold_results", 32'(acc_cnt - s_acc), 32'd1);
    stub_hold = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule
